// File: rtl/pc_pkg.sv
// Shared types and widths for the fetch-stage program-counter controller.
package pc_pkg;

    localparam int PC_W  = 12;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} pc_state_t;

    typedef logic [PC_W-1:0] pc_t;

endpackage : pc_pkg

// File: rtl/PC_LUT.sv
// Branch-target lookup: a purely combinational read of the target table.
module PC_LUT #(
    parameter int D = 12,
    parameter int B = 5
) (
    input  logic [D-1:0] tbl [2**B],
    input  logic [B-1:0] lut_idx,
    output logic [D-1:0] target
);

    // Select the indexed table entry
    always_comb begin
        target = tbl[lut_idx];
    end

endmodule : PC_LUT

// File: rtl/pc_ctrl.sv
// Program-counter controller: loads the branch target table from a stream,
// then sequences pc (increment / absolute / relative branch) with stall and halt.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int D = PC_W,
    parameter int B = IDX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         ld_valid,
    input  logic [D-1:0] ld_data,
    output logic         ld_ready,
    input  logic         branch,
    input  logic         rel,
    input  logic [B-1:0] lut_idx,
    input  logic         stall,
    input  logic         halt_req,
    output logic [D-1:0] pc,
    output logic         running,
    output logic         done
);

    pc_state_t    state_r;
    pc_state_t    state_next_s;
    logic [D-1:0] pc_r;
    logic [D-1:0] pc_next_s;
    logic [B-1:0] cnt_r;
    logic [B-1:0] cnt_next_s;
    logic         wr_en_s;
    logic         ld_ready_r;
    logic         running_r;
    logic         done_r;
    logic [D-1:0] table_r [2**B];
    logic [D-1:0] target_s;

    PC_LUT #(
        .D (D),
        .B (B)
    ) u_lut (
        .tbl     (table_r),
        .lut_idx (lut_idx),
        .target  (target_s)
    );

    // Next-state, next-pc and table-write decode
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        cnt_next_s   = cnt_r;
        wr_en_s      = 1'b0;
        case (state_r)
            IDLE: begin
                pc_next_s = {D{1'b0}};
                if (start) begin
                    state_next_s = LOAD;
                    cnt_next_s   = {B{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (ld_valid && ld_ready_r) begin
                    wr_en_s    = 1'b1;
                    cnt_next_s = cnt_r + {{(B-1){1'b0}}, 1'b1};
                    if (cnt_r == {B{1'b1}}) begin
                        state_next_s = RUN;
                        pc_next_s    = {D{1'b0}};
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            RUN: begin
                // Relative targets are two's-complement offsets; the carry is dropped.
                if (halt_req) begin
                    state_next_s = HALT;
                end else if (stall) begin
                    pc_next_s = pc_r;
                end else if (branch && !rel) begin
                    pc_next_s = target_s;
                end else if (branch && rel) begin
                    pc_next_s = pc_r + target_s;
                end else begin
                    pc_next_s = pc_r + {{(D-1){1'b0}}, 1'b1};
                end
            end
            HALT: begin
                if (start) begin
                    state_next_s = LOAD;
                    cnt_next_s   = {B{1'b0}};
                    pc_next_s    = {D{1'b0}};
                end else begin
                    state_next_s = HALT;
                end
            end
            default: begin
                state_next_s = IDLE;
                pc_next_s    = {D{1'b0}};
                cnt_next_s   = {B{1'b0}};
            end
        endcase
    end

    // FSM, pc, load counter and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            pc_r       <= {D{1'b0}};
            cnt_r      <= {B{1'b0}};
            ld_ready_r <= 1'b0;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            cnt_r      <= cnt_next_s;
            ld_ready_r <= (state_next_s == LOAD);
            running_r  <= (state_next_s == RUN);
            done_r     <= (state_next_s == HALT);
        end
    end

    // Branch target table; written only by accepted load beats
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**B; i++) begin
                table_r[i] <= {D{1'b0}};
            end
        end else if (wr_en_s) begin
            table_r[cnt_r] <= ld_data;
        end else begin
            table_r[cnt_r] <= table_r[cnt_r];
        end
    end

    assign pc       = pc_r;
    assign ld_ready = ld_ready_r;
    assign running  = running_r;
    assign done     = done_r;

endmodule : pc_ctrl

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter controller for the fetch stage. It owns the branch target table and loads it from a valid/ready stream after `start`. It then sequences the PC each cycle: increment, absolute branch, or PC-relative branch, with the target fetched from the table through a `PC_LUT` instance. Stall and halt are also handled here. The block sits between the instruction-memory address port and the decode stage's branch/halt signals.

## Interface
- D, 12, PC and table-entry width in bits
- B, 5, table index width; table depth is 2**B
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE and HALT
- ld_valid  in  1  load-stream data valid
- ld_data  in  D  table entry; entries arrive in index order 0..2**B-1
- ld_ready  out  1  load-stream ready; equals (state==LOAD)
- branch  in  1  take a branch this cycle (RUN only)
- rel  in  1  1 = target is a signed offset added to pc; 0 = absolute target
- lut_idx  in  B  table index of the branch target
- stall  in  1  hold pc this cycle
- halt_req  in  1  stop sequencing
- pc  out  D  current program counter, registered
- running  out  1  registered; equals (state==RUN)
- done  out  1  registered; equals (state==HALT)

## Operation
- States: IDLE, LOAD, RUN, HALT.
- Reset values:
  - state=IDLE, pc=0, load counter=0.
  - All 2**B table entries=0.
  - ld_ready=0, running=0, done=0.
- IDLE:
  - pc holds 0.
  - start → LOAD, with load counter cleared.
- LOAD:
  - A beat is accepted when ld_valid && ld_ready; it writes table[cnt]=ld_data and increments cnt.
  - ld_valid low inserts a gap; nothing is written and cnt holds.
  - Accepting the beat at cnt==2**B-1 → RUN, pc=0.
  - branch, stall, halt_req and start are ignored.
- RUN, priority per cycle (highest first):
  - halt_req: → HALT, pc holds.
  - stall: pc holds.
  - branch && !rel: pc = table[lut_idx].
  - branch && rel: pc = (pc + table[lut_idx]) mod 2**D. Two's-complement add with the carry dropped, so 0xFFF acts as −1.
  - otherwise: pc = (pc + 1) mod 2**D; 2**D-1 wraps to 0.
  - start is ignored.
- HALT:
  - pc holds and done=1.
  - start → LOAD with cnt=0; the table is fully reloaded and pc is cleared to 0 on entering LOAD.
- Reset has priority over everything, including mid-LOAD. Any partially written table entries return to 0.
- The table is writable only in LOAD and is read-only in RUN.

## Timing
- All outputs are registered, or decoded directly from registered state, and change only after a clk edge.
- start is sampled at edge N:
  - ld_ready=1 from cycle N+1.
  - A minimum-length load takes 2**B consecutive accepted beats.
  - running=1 and pc=0 in the cycle after the last accepted beat.
- Branch latency is 1 cycle: branch/rel/lut_idx sampled at edge N produce the new pc after edge N.
- The lut_idx→target path is combinational within the cycle. table writes and branch reads never coincide.
- halt_req sampled at edge N: done=1 and running=0 after edge N. The pc from cycle N is retained.
- stall and branch together: the stall wins and the branch is dropped. The requester must re-assert it.

## Structure
- Shared package `pc_pkg`:
  - `localparam PC_W=12, IDX_W=5`.
  - `typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} pc_state_t`.
  - `typedef logic [PC_W-1:0] pc_t`.
- One sub-module: `PC_LUT` (D, B), fed by the internal table array and lut_idx, returning the target.
- The table register array, load counter, FSM and pc register all live in `pc_ctrl`.

## Test plan
- Reset then idle: with no start, pc=0, ld_ready=0, running=0 and done=0 for 10 cycles.
- Gapped load:
  - Stimulus: start, then 32 beats with ld_valid toggling 1/0, entry i = 0x100+i.
  - Required: ld_ready stays high until the 32nd accepted beat; running=1 with pc=0 the next cycle; no extra entries written.
- Increment and wrap: after load, force pc to 0xFFE via an absolute branch to entry holding 0xFFE → pc sequence is 0xFFE, 0xFFF, 0x000, 0x001.
- Relative branches:
  - With table[3]=0xFFF at pc=4, branch with rel=1, idx=3 → pc=0x003.
  - With table[7]=0x014 at pc=0xFFB → pc=0x00F.
- Priorities:
  - stall+branch in the same cycle → pc unchanged, branch lost.
  - halt_req+branch → done=1 next cycle, pc unchanged.
  - start asserted during RUN → no effect.
- Halt/restart and reset mid-load:
  - start in HALT → ld_ready=1 next cycle and pc=0.
  - reset after 10 beats → all outputs at reset values.
  - A following start plus a full load of entry i = 0x200+i makes a branch to idx 5 give pc=0x205.
